// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite round-robin master arbiter.
// Holds the FSM state type, AXI response codes and a reference grant function.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Nearest asserted requester after last, wrapping mod n (n <= 8).
  function automatic logic [2:0] rr_next(
    input logic [7:0] req,
    input logic [2:0] last,
    input int         n
  );
    logic [2:0] g;
    g = last;
    for (int i = n; i >= 1; i--) begin
      int idx;
      idx = (int'(last) + i) % n;
      if (req[idx[2:0]]) g = idx[2:0];
    end
    return g;
  endfunction

endpackage

// File: rtl/axil_rr_master_arbiter_rr_grant.sv
// Round-robin grant: rotate so last+1 sits at bit 0, priority-encode,
// then rotate the winning offset back into a requester index.
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic               hit;
  int                 off;
  int                 pos;

  always_comb begin
    dbl = {req, req};
    rot = N_REQ'(dbl >> (int'(last) + 1));
    off = 0;
    hit = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!hit && rot[j]) begin
        off = j;
        hit = 1'b1;
      end
    end
    pos = int'(last) + 1 + off;
    if (pos >= N_REQ) pos = pos - N_REQ;
    grant_idx   = IDX_W'(pos);
    grant_valid = hit;
  end

endmodule

// File: rtl/axil_rr_master_arbiter.sv
// Shares one AXI4-Lite master port among N_REQ single-beat requesters,
// one transaction in flight, responses routed back to the granted requester.
module axil_rr_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             req_we,
  input  logic [N_REQ*ADDR_W-1:0]      req_addr,
  input  logic [N_REQ*DATA_W-1:0]      req_wdata,
  input  logic [N_REQ*(DATA_W/8)-1:0]  req_wstrb,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         busy,
  output logic [15:0]                  txn_count,
  output logic [ADDR_W-1:0]            M_AXI_AWADDR,
  output logic [2:0]                   M_AXI_AWPROT,
  output logic                         M_AXI_AWVALID,
  input  logic                         M_AXI_AWREADY,
  output logic [DATA_W-1:0]            M_AXI_WDATA,
  output logic [DATA_W/8-1:0]          M_AXI_WSTRB,
  output logic                         M_AXI_WVALID,
  input  logic                         M_AXI_WREADY,
  input  logic [1:0]                   M_AXI_BRESP,
  input  logic                         M_AXI_BVALID,
  output logic                         M_AXI_BREADY,
  output logic [ADDR_W-1:0]            M_AXI_ARADDR,
  output logic [2:0]                   M_AXI_ARPROT,
  output logic                         M_AXI_ARVALID,
  input  logic                         M_AXI_ARREADY,
  input  logic [DATA_W-1:0]            M_AXI_RDATA,
  input  logic [1:0]                   M_AXI_RRESP,
  input  logic                         M_AXI_RVALID,
  output logic                         M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [15:0]         txn_q, txn_d;

  logic [IDX_W-1:0]    g_idx;
  logic                g_vld;
  int                  gi;

  rr_grant #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_grant (
    .req         (req_valid),
    .last        (last_q),
    .grant_idx   (g_idx),
    .grant_valid (g_vld)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rdata_d       = rdata_q;
    resp_d        = resp_q;
    txn_d         = txn_q;
    gi            = int'(g_idx);
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_rdata     = '0;
    rsp_resp      = RESP_OKAY;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (g_vld) begin
          req_ready[g_idx] = 1'b1;
          addr_d    = req_addr[gi*ADDR_W +: ADDR_W];
          wdata_d   = req_wdata[gi*DATA_W +: DATA_W];
          wstrb_d   = req_wstrb[gi*STRB_W +: STRB_W];
          last_d    = g_idx;
          gnt_d     = g_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we[g_idx] ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently; either may be accepted first.
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        aw_done_d     = aw_done_q | M_AXI_AWREADY;
        w_done_d      = w_done_q | M_AXI_WREADY;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = RSP;
        end
      end
      RSP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_rdata = rdata_q;
        rsp_resp  = resp_q;
        txn_d     = txn_q + 16'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(N_REQ - 1);
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      txn_q     <= txn_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign txn_count    = txn_q;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

endmodule

// File: tb/tb_axil_rr_master_arbiter.sv
// Directed bench for axil_rr_master_arbiter with a latency-programmable
// AXI4-Lite slave and a negedge monitor logging grants and responses.
module tb_axil_rr_master_arbiter;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [3:0]   req_we = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [15:0]  req_wstrb = '0;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic [1:0]   rsp_resp;
  logic         busy;
  logic [15:0]  txn_count;
  logic [31:0]  AWADDR, WDATA, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic [3:0]   WSTRB;
  logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic         AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic         ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]   BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0]  RDATA = '0;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  b_resp = 2'b00;
  logic [31:0] rd_val = '0;

  logic [3:0]  gnt_vec[$];
  int          gnt_cyc[$];
  logic [3:0]  rsp_vec[$];
  logic [31:0] rsp_dat[$];
  logic [1:0]  rsp_rsp[$];
  int          rsp_cyc[$];
  int          busy_cnt, aw_vcnt, w_vcnt, aw_hs_cnt, bready_early;
  bit          aw_moved, aw_hs_seen, w_hs_seen;
  logic [31:0] aw_first, last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;

  axil_rr_master_arbiter dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .busy          (busy),
    .txn_count     (txn_count),
    .M_AXI_AWADDR  (AWADDR),
    .M_AXI_AWPROT  (AWPROT),
    .M_AXI_AWVALID (AWVALID),
    .M_AXI_AWREADY (AWREADY),
    .M_AXI_WDATA   (WDATA),
    .M_AXI_WSTRB   (WSTRB),
    .M_AXI_WVALID  (WVALID),
    .M_AXI_WREADY  (WREADY),
    .M_AXI_BRESP   (BRESP),
    .M_AXI_BVALID  (BVALID),
    .M_AXI_BREADY  (BREADY),
    .M_AXI_ARADDR  (ARADDR),
    .M_AXI_ARPROT  (ARPROT),
    .M_AXI_ARVALID (ARVALID),
    .M_AXI_ARREADY (ARREADY),
    .M_AXI_RDATA   (RDATA),
    .M_AXI_RRESP   (RRESP),
    .M_AXI_RVALID  (RVALID),
    .M_AXI_RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Slave: each ready/valid fires after its programmed number of wait cycles.
  always begin
    @(posedge ACLK);
    #1;
    if (AWVALID && aw_cnt == aw_lat) begin AWREADY = 1'b1; aw_cnt = 0; end
    else if (AWVALID) begin AWREADY = 1'b0; aw_cnt++; end
    else begin AWREADY = 1'b0; aw_cnt = 0; end
    if (WVALID && w_cnt == w_lat) begin WREADY = 1'b1; w_cnt = 0; end
    else if (WVALID) begin WREADY = 1'b0; w_cnt++; end
    else begin WREADY = 1'b0; w_cnt = 0; end
    if (ARVALID && ar_cnt == ar_lat) begin ARREADY = 1'b1; ar_cnt = 0; end
    else if (ARVALID) begin ARREADY = 1'b0; ar_cnt++; end
    else begin ARREADY = 1'b0; ar_cnt = 0; end
    if (BREADY && b_cnt == b_lat) begin
      BVALID = 1'b1; BRESP = b_resp; b_cnt = 0;
    end else if (BREADY) begin BVALID = 1'b0; b_cnt++; end
    else begin BVALID = 1'b0; BRESP = 2'b00; b_cnt = 0; end
    if (RREADY && r_cnt == r_lat) begin
      RVALID = 1'b1; RDATA = rd_val; RRESP = 2'b00; r_cnt = 0;
    end else if (RREADY) begin RVALID = 1'b0; r_cnt++; end
    else begin RVALID = 1'b0; RDATA = '0; r_cnt = 0; end
  end

  always @(negedge ACLK) begin
    if (|req_ready) begin
      gnt_vec.push_back(req_ready);
      gnt_cyc.push_back(cyc);
    end
    if (|rsp_valid) begin
      rsp_vec.push_back(rsp_valid);
      rsp_dat.push_back(rsp_rdata);
      rsp_rsp.push_back(rsp_resp);
      rsp_cyc.push_back(cyc);
    end
    if (busy) busy_cnt++;
    if (AWVALID) begin
      if (aw_vcnt == 0) aw_first = AWADDR;
      else if (AWADDR !== aw_first) aw_moved = 1'b1;
      aw_vcnt++;
    end
    if (WVALID) w_vcnt++;
    if (BREADY && !(aw_hs_seen && w_hs_seen)) bready_early++;
    if (AWVALID && AWREADY) begin
      aw_hs_cnt++;
      aw_hs_seen  = 1'b1;
      last_awaddr = AWADDR;
    end
    if (WVALID && WREADY) begin
      w_hs_seen  = 1'b1;
      last_wdata = WDATA;
      last_wstrb = WSTRB;
    end
    if (ARVALID && ARREADY) last_araddr = ARADDR;
  end

  task automatic clear_logs();
    gnt_vec.delete(); gnt_cyc.delete();
    rsp_vec.delete(); rsp_dat.delete();
    rsp_rsp.delete(); rsp_cyc.delete();
    busy_cnt = 0; aw_vcnt = 0; w_vcnt = 0;
    aw_hs_cnt = 0; bready_early = 0;
    aw_moved = 1'b0; aw_hs_seen = 1'b0; w_hs_seen = 1'b0;
    last_awaddr = '0; last_wdata = '0;
    last_wstrb = '0; last_araddr = '0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  task automatic drive_req(input int i, input logic we,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    req_we[i] = we;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int k;
    bit got;
    k = 0;
    got = 1'b0;
    while (!got && k < 100) begin
      @(negedge ACLK);
      if (req_ready[i]) got = 1'b1;
      k++;
    end
    vec++;
    if (!got) begin
      errs++;
      $display("FAIL grant_wait[%0d]: no req_ready, required one", i);
    end
    @(posedge ACLK);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_vec.size() < n && k < 200) begin
      @(posedge ACLK);
      #1;
      k++;
    end
    vec++;
    if (rsp_vec.size() < n) begin
      errs++;
      $display("FAIL rsp_wait: got %0d responses, required %0d",
               rsp_vec.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rst_busy: got %b, required 0", busy);
    end
    vec++;
    if (txn_count !== 16'd0) begin
      errs++; $display("FAIL rst_txn: got %0d, required 0", txn_count);
    end
    vec++;
    if (rsp_valid !== 4'b0) begin
      errs++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid);
    end
    vec++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 5'b0) begin
      errs++;
      $display("FAIL rst_axi: got %b, required 00000",
               {AWVALID, WVALID, ARVALID, BREADY, RREADY});
    end
    vec++;
    if ({rsp_rdata, rsp_resp} !== 34'd0) begin
      errs++;
      $display("FAIL rst_rsp_data: got %h/%b, required 0", rsp_rdata, rsp_resp);
    end
  endtask

  task automatic test_write0();
    clear_logs();
    drive_req(0, 1'b1, 32'h4000_0000, 32'hDEAD_A5A5, 4'hF);
    wait_grant(0);
    wait_rsp(1);
    vec++;
    if (last_awaddr !== 32'h4000_0000) begin
      errs++; $display("FAIL wr_awaddr: got %h, required 40000000", last_awaddr);
    end
    vec++;
    if ({last_wdata, last_wstrb} !== {32'hDEAD_A5A5, 4'hF}) begin
      errs++;
      $display("FAIL wr_wdata: got %h/%h, required deada5a5/f",
               last_wdata, last_wstrb);
    end
    vec++;
    if (rsp_vec[0] !== 4'b0001 || rsp_rsp[0] !== 2'b00) begin
      errs++;
      $display("FAIL wr_rsp: got %b/%b, required 0001/00", rsp_vec[0], rsp_rsp[0]);
    end
    vec++;
    if (rsp_dat[0] !== 32'd0) begin
      errs++; $display("FAIL wr_rdata: got %h, required 0", rsp_dat[0]);
    end
    vec++;
    if (rsp_cyc[0] - gnt_cyc[0] !== 3) begin
      errs++;
      $display("FAIL wr_latency: got %0d, required 3", rsp_cyc[0] - gnt_cyc[0]);
    end
    vec++;
    if (txn_count !== 16'd1) begin
      errs++; $display("FAIL wr_txn: got %0d, required 1", txn_count);
    end
  endtask

  task automatic test_read_wait();
    r_lat = 3;
    rd_val = 32'h0000_0005;
    clear_logs();
    drive_req(2, 1'b0, 32'h4000_0008, 32'h0, 4'h0);
    wait_grant(2);
    wait_rsp(1);
    vec++;
    if (gnt_vec[0] !== 4'b0100) begin
      errs++; $display("FAIL rd_grant: got %b, required 0100", gnt_vec[0]);
    end
    vec++;
    if (last_araddr !== 32'h4000_0008) begin
      errs++; $display("FAIL rd_araddr: got %h, required 40000008", last_araddr);
    end
    vec++;
    if (rsp_vec[0] !== 4'b0100) begin
      errs++; $display("FAIL rd_rsp_valid: got %b, required 0100", rsp_vec[0]);
    end
    vec++;
    if (rsp_dat[0] !== 32'h5 || rsp_rsp[0] !== 2'b00) begin
      errs++;
      $display("FAIL rd_rsp_data: got %h/%b, required 5/00", rsp_dat[0], rsp_rsp[0]);
    end
    vec++;
    if (rsp_cyc[0] - gnt_cyc[0] !== 6) begin
      errs++;
      $display("FAIL rd_latency: got %0d, required 6", rsp_cyc[0] - gnt_cyc[0]);
    end
    vec++;
    if (busy_cnt !== 6) begin
      errs++; $display("FAIL rd_busy: got %0d busy cycles, required 6", busy_cnt);
    end
    r_lat = 0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      drive_req(i, logic'(i % 2), 32'h4000_0000 + 32'(4 * i),
                32'h100 + 32'(i), 4'hF);
    end
    wait_rsp(8);
    req_valid = '0;
    vec++;
    if (txn_count !== 16'd8) begin
      errs++; $display("FAIL rr_txn: got %0d, required 8", txn_count);
    end
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      vec++;
      if (gnt_vec[k] !== exp || rsp_vec[k] !== exp) begin
        errs++;
        $display("FAIL rr_order[%0d]: got %b/%b, required %b",
                 k, gnt_vec[k], rsp_vec[k], exp);
      end
    end
    vec++;
    if (gnt_cyc[1] - gnt_cyc[0] !== 4) begin
      errs++;
      $display("FAIL rr_spacing: got %0d, required 4", gnt_cyc[1] - gnt_cyc[0]);
    end
    repeat (3) @(posedge ACLK);
    #1;
    vec++;
    if (gnt_vec.size() !== 8) begin
      errs++; $display("FAIL rr_count: got %0d grants, required 8", gnt_vec.size());
    end
  endtask

  task automatic test_aw_stall();
    aw_lat = 5;
    clear_logs();
    drive_req(3, 1'b1, 32'h4000_0004, 32'h1234_5678, 4'b0011);
    wait_grant(3);
    wait_rsp(1);
    vec++;
    if (aw_vcnt !== 6 || aw_moved !== 1'b0) begin
      errs++;
      $display("FAIL aw_hold: got %0d cycles moved=%b, required 6/0",
               aw_vcnt, aw_moved);
    end
    vec++;
    if (w_vcnt !== 1) begin
      errs++; $display("FAIL w_drop: got %0d WVALID cycles, required 1", w_vcnt);
    end
    vec++;
    if (bready_early !== 0) begin
      errs++;
      $display("FAIL bready_early: got %0d early cycles, required 0", bready_early);
    end
    vec++;
    if ({last_wdata, last_wstrb} !== {32'h1234_5678, 4'b0011}) begin
      errs++;
      $display("FAIL aw_wdata: got %h/%b, required 12345678/0011",
               last_wdata, last_wstrb);
    end
    vec++;
    if (rsp_vec[0] !== 4'b1000 || rsp_cyc[0] - gnt_cyc[0] !== 8) begin
      errs++;
      $display("FAIL aw_rsp: got %b after %0d, required 1000 after 8",
               rsp_vec[0], rsp_cyc[0] - gnt_cyc[0]);
    end
    aw_lat = 0;
  endtask

  task automatic test_slverr();
    b_resp = 2'b10;
    clear_logs();
    drive_req(1, 1'b1, 32'h4000_0000, 32'h0000_000A, 4'hF);
    wait_grant(1);
    wait_rsp(1);
    repeat (6) @(posedge ACLK);
    #1;
    vec++;
    if (rsp_vec[0] !== 4'b0010 || rsp_rsp[0] !== 2'b10) begin
      errs++;
      $display("FAIL slverr_rsp: got %b/%b, required 0010/10", rsp_vec[0], rsp_rsp[0]);
    end
    vec++;
    if (aw_hs_cnt !== 1 || rsp_vec.size() !== 1) begin
      errs++;
      $display("FAIL slverr_retry: got %0d AW / %0d rsp, required 1/1",
               aw_hs_cnt, rsp_vec.size());
    end
    b_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    int k;
    r_lat = 20;
    clear_logs();
    drive_req(2, 1'b0, 32'h4000_0010, 32'h0, 4'h0);
    wait_grant(2);
    k = 0;
    while (!RREADY && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    vec++;
    if (RREADY !== 1'b1) begin
      errs++; $display("FAIL mid_rd_data: got RREADY %b, required 1", RREADY);
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    r_lat = 0;
    vec++;
    if (busy !== 1'b0 || txn_count !== 16'd0) begin
      errs++;
      $display("FAIL mid_rst_state: got busy=%b txn=%0d, required 0/0",
               busy, txn_count);
    end
    vec++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid} !== 9'd0) begin
      errs++;
      $display("FAIL mid_rst_outs: got %b, required 0",
               {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid});
    end
    vec++;
    if (rsp_vec.size() !== 0) begin
      errs++;
      $display("FAIL mid_rst_rsp: got %0d responses, required 0", rsp_vec.size());
    end
    clear_logs();
    drive_req(3, 1'b0, 32'h4000_000C, 32'h0, 4'h0);
    drive_req(0, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
    wait_grant(0);
    wait_grant(3);
    wait_rsp(2);
    vec++;
    if (gnt_vec[0] !== 4'b0001 || gnt_vec[1] !== 4'b1000) begin
      errs++;
      $display("FAIL mid_rst_order: got %b,%b, required 0001,1000",
               gnt_vec[0], gnt_vec[1]);
    end
    vec++;
    if (rsp_vec[0] !== 4'b0001 || rsp_vec[1] !== 4'b1000) begin
      errs++;
      $display("FAIL mid_rst_rsp_order: got %b,%b, required 0001,1000",
               rsp_vec[0], rsp_vec[1]);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_write0();
    test_read_wait();
    test_round_robin();
    test_aw_stall();
    test_slverr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/axil_rr_master_arbiter.md
Name: axil_rr_master_arbiter

Overview:
Round-robin arbiter that shares one AXI4-Lite master port between N_REQ independent single-beat requesters, such as DPI-driven stimulus agents and PL sequencers. The port targets the GPIO/LED slave at 0x4000_0000 and similar peripherals. Each granted request becomes exactly one AXI4-Lite write or read, and its response is routed back to the originating requester. Only one transaction is outstanding at a time, so responses are strictly ordered.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (32 only; WSTRB is DATA_W/8 bits)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request valid; held until req_ready
req_ready  out  N_REQ  one-hot grant/accept pulse
req_we  in  N_REQ  1=write, 0=read
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice i
req_wdata  in  N_REQ*DATA_W  packed write data
req_wstrb  in  N_REQ*DATA_W/8  packed byte strobes
rsp_valid  out  N_REQ  one-hot, one-cycle response pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_resp  out  2  BRESP/RRESP, valid with rsp_valid
busy  out  1  transaction in flight
txn_count  out  16  completed transactions, wraps
M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master; AWPROT/ARPROT tied 3'b000

Behaviour:
- Reset (ARESET=1 at posedge): FSM=IDLE; last_grant=N_REQ-1, so requester 0 wins first; all outputs 0, including every *VALID, BREADY, RREADY, req_ready, rsp_valid, rsp_rdata, rsp_resp, busy and txn_count.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE, any req_valid:
  - Grant the first asserted requester searching upward (mod N_REQ) from last_grant+1.
  - Assert req_ready[g] combinationally for that cycle.
  - Latch addr, wdata, wstrb, we and g; update last_grant=g.
  - Go to WR_ADDR if we=1, else RD_ADDR.
- WR_ADDR: AWVALID and WVALID both asserted from the cycle after the grant. Each drops independently on its own handshake (aw_done/w_done flags). When both are done, or both handshakes occur in the same cycle, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to RSP.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA and RRESP, then go to RSP.
- RSP:
  - rsp_valid[g]=1 for exactly one cycle, with rsp_rdata/rsp_resp stable; rsp_rdata=0 for writes.
  - txn_count increments, wrapping 0xFFFF to 0.
  - Return to IDLE.
- Minimum latency, zero-wait slave:
  - Write: grant cycle 0, AW/W handshake cycle 1, B cycle 2, rsp_valid cycle 3.
  - Read: grant cycle 0, AR cycle 1, R cycle 2, rsp_valid cycle 3.
  - Next grant is possible in cycle 4.
- busy=1 in every state except IDLE.
- Once asserted, a VALID is never withdrawn before its READY. AXI inputs are ignored outside their state.
- A requester deasserting req_valid without a grant is legal; nothing is recorded.
- A requester may re-request in the cycle after its rsp_valid. Round robin guarantees that no requester waits more than N_REQ-1 other transactions.
- ARESET mid-transaction aborts immediately and all outputs return to reset values. The system resets the slave together with the arbiter.
- SLVERR/DECERR are passed through unchanged; no retry.

Decomposition:
- Package axil_arb_pkg:
  - state_t enum.
  - AXI response constants: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Function rr_next(req, last) returning the grant index.
- Sub-module rr_grant (parameter N_REQ): combinational rotate, priority-encode, unrotate; outputs grant_idx and grant_valid. It is reused by future arbiters.

Test Plan:
- Reset, then requester 0 writes 0x4000_0000 = 0xDEADA5A5 with wstrb 0xF:
  - AWADDR=0x4000_0000, WDATA=0xDEADA5A5.
  - rsp_valid=4'b0001, rsp_resp=0 at cycle 3.
  - txn_count=1.
- Requester 2 reads 0x4000_0008; slave returns 0x0000_0005 after 3 wait cycles on RVALID:
  - rsp_valid=4'b0100, rsp_rdata=0x5, rsp_resp=0.
  - busy=1 throughout until the RSP cycle.
- All 4 requesters assert simultaneously and continuously for 8 transactions: grant order is 0,1,2,3,0,1,2,3 and txn_count=8.
- Slave withholds AWREADY 5 cycles and accepts W first:
  - AWVALID held stable 5 cycles.
  - WVALID drops after its handshake.
  - BREADY is asserted only after both handshakes.
- Slave returns BRESP=2'b10 for requester 1: rsp_resp=2'b10 on rsp_valid[1]; no retry is issued.
- ARESET=1 pulsed while in RD_DATA:
  - Next cycle all outputs are 0, busy=0 and txn_count=0.
  - Subsequent requests from requesters 3 and 0 grant 0 first.
